park_access_ctrl: RTL
=====================

PARK_ACCESS_CTRL -- requirements
Module: park_access_ctrl

Interface
REQ-001 Parameter AUTH_ID0, default 28'h2021001, authorized 7-digit BCD ID, slot 0.
REQ-002 Parameter AUTH_ID1, default 28'h2021002, authorized ID, slot 1.
REQ-003 Parameter AUTH_ID2, default 28'h2021003, authorized ID, slot 2.
REQ-004 Parameter AUTH_ID3, default 28'h2021004, authorized ID, slot 3.
REQ-005 Parameter CAPACITY, default 3, max simultaneously parked IDs (1..4).
REQ-006 Parameter HOLD_CYCLES, default 50_000_000, GRANTED/DENIED display duration in clocks (>=2).
REQ-007 iCLK  input  1  system clock; all state changes on rising edge.
REQ-008 iRST_N  input  1  reset, asynchronous, active-low.
REQ-009 iPOWER  input  1  level; 0 = parking off.
REQ-010 iADMIN  input  1  level; 1 = request administrator mode.
REQ-011 iKEY_VALID  input  1  one-cycle strobe qualifying iKEY_CODE.
REQ-012 iKEY_CODE  input  4  0-9 digit, 0xA clear, 0xB enter, 0xC toggle entry/exit; 0xD-0xF ignored.
REQ-013 LCD_State  output  4  display state code for the LCD stage: 0 ENTRY, 1 GRANTED, 2 DENIED, 3 EXIT, 4 ADMIN, 15 OFF.
REQ-014 ID  output  28  7 BCD digits, most significant digit in [27:24].
REQ-015 oGATE_OPEN  output  1  high exactly while LCD_State = 1.
REQ-016 oOCCUPIED  output  3  number of set parked bits (0..4).

Function
REQ-017 All outputs SHALL be registered; a key strobe at edge t SHALL be reflected on outputs after edge t.
REQ-018 iPOWER=0 SHALL force OFF from any state on the next edge, highest priority; digit buffer cleared, parked bits retained.
REQ-019 OFF with iPOWER=1 SHALL go to ENTRY on the next edge.
REQ-020 In ENTRY/EXIT, iADMIN=1 SHALL go to ADMIN (priority below power, above keys); in ADMIN, iADMIN=0 SHALL return to ENTRY.
REQ-021 In ENTRY/EXIT, a digit key with count<7 SHALL shift in: ID <= {ID[23:0], digit}, count+1; digits at count=7 ignored.
REQ-022 In ENTRY/EXIT, key 0xA SHALL clear ID and count to 0.
REQ-023 In ENTRY/EXIT, key 0xC SHALL toggle ENTRY<->EXIT and clear ID and count.
REQ-024 Enter in ENTRY SHALL grant iff count=7, ID matches slot i, parked[i]=0, occupancy<CAPACITY; grant sets parked[i].
REQ-025 Enter in EXIT SHALL grant iff count=7, ID matches slot i, parked[i]=1; grant clears parked[i].
REQ-026 If an ID matches several slots, the lowest index SHALL be used.
REQ-027 Failed enter SHALL go to DENIED; ID cleared to 0 on entering DENIED; ID held unchanged through GRANTED.
REQ-028 GRANTED/DENIED SHALL last exactly HOLD_CYCLES clocks, then return to the originating mode (ENTRY or EXIT) with ID and count cleared.
REQ-029 Key strobes during GRANTED, DENIED, OFF SHALL be ignored; in ADMIN only key 0xA acts, clearing all parked bits.
REQ-030 iADMIN during GRANTED/DENIED SHALL be ignored until the hold expires.
REQ-031 oOCCUPIED SHALL equal popcount(parked) at all times after reset.

Reset
REQ-032 iRST_N=0 SHALL immediately set LCD_State=15, ID=0, count=0, parked=0, oGATE_OPEN=0, oOCCUPIED=0, hold timer=0, mode=ENTRY.
REQ-033 Reset release with iPOWER=1 SHALL reach ENTRY on the first edge; reset asserted mid-GRANTED SHALL abort the grant and clear parked bits.

Verification (HOLD_CYCLES=4)
REQ-034 Keys 2,0,2,1,0,0,1, 0xB in ENTRY -> LCD_State=1, ID=28'h2021001, oGATE_OPEN=1 for 4 cycles, oOCCUPIED=1, then LCD_State=0, ID=0.
REQ-035 Same ID re-entered in ENTRY -> LCD_State=2, ID=0, oOCCUPIED unchanged at 1.
REQ-036 IDs 2021001..2021003 granted, then 2021004 entered -> LCD_State=2 (full), oOCCUPIED=3.
REQ-037 Key 0xC, then 2021002 + 0xB -> LCD_State=1 for 4 cycles, oOCCUPIED=2, returns to LCD_State=3.
REQ-038 Six digits + 0xB -> LCD_State=2; digit keys during DENIED do not change ID.
REQ-039 iPOWER=0 mid-GRANTED -> LCD_State=15 next edge, oGATE_OPEN=0; iADMIN=1 + 0xA in ADMIN -> oOCCUPIED=0.

Source files
------------

// File: rtl/park_access_ctrl.sv
// ---------------------------------------------------------------------------
// park_access_ctrl
//   Keypad-driven parking gate controller. A 7-digit BCD ID is typed on a
//   keypad and checked against up to four authorized IDs. In ENTRY mode a
//   valid ID that is not parked is admitted (if the lot is not full). In
//   EXIT mode a parked ID is let out. The GRANTED/DENIED result is held for
//   HOLD_CYCLES clocks, and then the controller returns to the mode it came
//   from. An administrator mode can clear all parked slots.
//
// Ports
//   iCLK        system clock, rising edge
//   iRST_N      asynchronous active-low reset
//   iPOWER      level, 0 = parking off (highest priority)
//   iADMIN      level, 1 = request administrator mode
//   iKEY_VALID  one-cycle strobe qualifying iKEY_CODE
//   iKEY_CODE   0-9 digit, A clear, B enter, C toggle entry/exit, D-F unused
//   LCD_State   0 ENTRY, 1 GRANTED, 2 DENIED, 3 EXIT, 4 ADMIN, 15 OFF
//   ID          7 BCD digits being typed / granted, MS digit in [27:24]
//   oGATE_OPEN  high exactly while LCD_State is GRANTED
//   oOCCUPIED   number of parked slots
// ---------------------------------------------------------------------------
module park_access_ctrl #(
    parameter logic [27:0] AUTH_ID0    = 28'h2021001,
    parameter logic [27:0] AUTH_ID1    = 28'h2021002,
    parameter logic [27:0] AUTH_ID2    = 28'h2021003,
    parameter logic [27:0] AUTH_ID3    = 28'h2021004,
    parameter int          CAPACITY    = 3,
    parameter int          HOLD_CYCLES = 50_000_000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iPOWER,
    input  logic        iADMIN,
    input  logic        iKEY_VALID,
    input  logic [3:0]  iKEY_CODE,
    output logic [3:0]  LCD_State,
    output logic [27:0] ID,
    output logic        oGATE_OPEN,
    output logic [2:0]  oOCCUPIED
);

    // State encodings equal the LCD codes, so the state register drives
    // LCD_State directly.
    typedef enum logic [3:0] {
        ST_ENTRY   = 4'd0,
        ST_GRANTED = 4'd1,
        ST_DENIED  = 4'd2,
        ST_EXIT    = 4'd3,
        ST_ADMIN   = 4'd4,
        ST_OFF     = 4'd15
    } state_t;

    // The hold timer counts 0 .. HOLD_CYCLES-1.
    localparam int             HW        = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]     CAP       = 3'(CAPACITY);

    state_t         r_state,  w_state_nxt;
    logic           r_mode,   w_mode_nxt;    // 0 = ENTRY, 1 = EXIT
    logic [27:0]    r_id,     w_id_nxt;
    logic [2:0]     r_count,  w_count_nxt;
    logic [3:0]     r_parked, w_parked_nxt;
    logic [HW-1:0]  r_hold,   w_hold_nxt;
    logic           r_gate;
    logic [2:0]     r_occ;

    logic           w_match;
    logic [1:0]     w_slot;
    logic           w_grant;
    logic [2:0]     w_occ_nxt;

    // If an ID matches several slots, the lowest index wins.
    always_comb begin
        w_match = 1'b1;
        w_slot  = 2'd0;
        if      (r_id == AUTH_ID0) w_slot = 2'd0;
        else if (r_id == AUTH_ID1) w_slot = 2'd1;
        else if (r_id == AUTH_ID2) w_slot = 2'd2;
        else if (r_id == AUTH_ID3) w_slot = 2'd3;
        else                       w_match = 1'b0;
    end

    // Entering needs a free slot and room in the lot. Exiting needs the
    // slot to be parked.
    assign w_grant = (r_count == 3'd7) && w_match &&
                     (r_mode ? r_parked[w_slot]
                             : (!r_parked[w_slot] && (r_occ < CAP)));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_id_nxt     = r_id;
        w_count_nxt  = r_count;
        w_parked_nxt = r_parked;
        w_hold_nxt   = r_hold;

        if (!iPOWER) begin
            // Power off overrides everything. Parked bits survive.
            w_state_nxt = ST_OFF;
            w_id_nxt    = '0;
            w_count_nxt = '0;
            w_hold_nxt  = '0;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_ENTRY;
                    w_mode_nxt  = 1'b0;
                end
                ST_ENTRY, ST_EXIT: begin
                    if (iADMIN) begin
                        w_state_nxt = ST_ADMIN;
                        w_id_nxt    = '0;
                        w_count_nxt = '0;
                    end else if (iKEY_VALID) begin
                        case (iKEY_CODE)
                            4'hA: begin
                                w_id_nxt    = '0;
                                w_count_nxt = '0;
                            end
                            4'hB: begin
                                w_hold_nxt = '0;
                                if (w_grant) begin
                                    // ID stays on display through GRANTED.
                                    w_state_nxt          = ST_GRANTED;
                                    w_parked_nxt[w_slot] = ~r_mode;
                                end else begin
                                    w_state_nxt = ST_DENIED;
                                    w_id_nxt    = '0;
                                    w_count_nxt = '0;
                                end
                            end
                            4'hC: begin
                                w_mode_nxt  = ~r_mode;
                                w_state_nxt = r_mode ? ST_ENTRY : ST_EXIT;
                                w_id_nxt    = '0;
                                w_count_nxt = '0;
                            end
                            default: begin
                                // Digits shift in until 7 are held. D-F
                                // fall through here and are ignored.
                                if (iKEY_CODE <= 4'd9 && r_count != 3'd7) begin
                                    w_id_nxt    = {r_id[23:0], iKEY_CODE};
                                    w_count_nxt = r_count + 3'd1;
                                end
                            end
                        endcase
                    end
                end
                ST_GRANTED, ST_DENIED: begin
                    // Keys and iADMIN are ignored until the hold expires.
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt = r_mode ? ST_EXIT : ST_ENTRY;
                        w_id_nxt    = '0;
                        w_count_nxt = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
                ST_ADMIN: begin
                    if (!iADMIN) begin
                        w_state_nxt = ST_ENTRY;
                        w_mode_nxt  = 1'b0;
                    end else if (iKEY_VALID && iKEY_CODE == 4'hA) begin
                        w_parked_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    assign w_occ_nxt = 3'(w_parked_nxt[0]) + 3'(w_parked_nxt[1]) +
                       3'(w_parked_nxt[2]) + 3'(w_parked_nxt[3]);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, whatever order the statements run in.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= ST_OFF;
            r_mode   <= 1'b0;
            r_id     <= '0;
            r_count  <= '0;
            r_parked <= '0;
            r_hold   <= '0;
            r_gate   <= 1'b0;
            r_occ    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_id     <= w_id_nxt;
            r_count  <= w_count_nxt;
            r_parked <= w_parked_nxt;
            r_hold   <= w_hold_nxt;
            r_gate   <= (w_state_nxt == ST_GRANTED);
            r_occ    <= w_occ_nxt;
        end
    end

    assign LCD_State  = r_state;
    assign ID         = r_id;
    assign oGATE_OPEN = r_gate;
    assign oOCCUPIED  = r_occ;

endmodule
